ddr_wr_arbiter: RTL and testbench

DDR_WR_ARBITER -- requirements
Module: ddr_wr_arbiter

---
 rtl/ddr_wr_arbiter_if.sv | 31 +++
 rtl/ddr_wr_arbiter.sv | 121 ++++++++++++
 tb/tb_ddr_wr_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_wr_arbiter_if.sv
// Requester-side and DDR-write-engine-side signal bundle for the 3-way DDR write arbiter.
// The master modport is the arbiter's view; slave is the environment (requesters + engine).
interface ddr_wr_arbiter_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int LEN_WIDTH  = 16,
  parameter int DQ_WIDTH   = 32
);
  logic [2:0]                  req_wreq;
  logic [3*ADDR_WIDTH-1:0]     req_waddr;
  logic [3*LEN_WIDTH-1:0]      req_wr_len;
  logic [3*8*DQ_WIDTH-1:0]     req_wdata;
  logic [2:0]                  req_wdata_req;
  logic [2:0]                  req_wdone;

  logic                        ddr_wreq;
  logic [ADDR_WIDTH-1:0]       ddr_waddr;
  logic [LEN_WIDTH-1:0]        ddr_wr_len;
  logic [8*DQ_WIDTH-1:0]       ddr_wdata;
  logic                        ddr_wdata_req;
  logic                        ddr_wdone;

  modport master (
    input  req_wreq, req_waddr, req_wr_len, req_wdata, ddr_wdata_req, ddr_wdone,
    output req_wdata_req, req_wdone, ddr_wreq, ddr_waddr, ddr_wr_len, ddr_wdata
  );

  modport slave (
    output req_wreq, req_waddr, req_wr_len, req_wdata, ddr_wdata_req, ddr_wdone,
    input  req_wdata_req, req_wdone, ddr_wreq, ddr_waddr, ddr_wr_len, ddr_wdata
  );
endinterface

// File: rtl/ddr_wr_arbiter.sv
// Round-robin arbiter sharing one DDR write engine among three requesters,
// with a sticky flag for bursts whose delivered beat count differs from the requested length.
module ddr_wr_arbiter #(
  parameter int ADDR_WIDTH = 27,
  parameter int LEN_WIDTH  = 16,
  parameter int DQ_WIDTH   = 32
) (
  input  logic             ddr_clk,
  input  logic             ddr_rst,
  ddr_wr_arbiter_if.master bus,
  output logic [1:0]       grant,
  output logic             len_err
);
  localparam int DATA_WIDTH = 8 * DQ_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DATA = 2'd2} state_t;

  state_t                 state_reg, state_next;
  logic [1:0]             grant_reg, last_grant_reg;
  logic [ADDR_WIDTH-1:0]  waddr_reg;
  logic [LEN_WIDTH-1:0]   wr_len_reg;
  logic [LEN_WIDTH-1:0]   beat_cnt_reg;
  logic [LEN_WIDTH-1:0]   beat_total;
  logic                   len_err_reg;
  logic [1:0]             pick;
  logic                   busy, start, finish;
  logic [DATA_WIDTH-1:0]  req_data [3];

  function automatic logic [1:0] rr_index(input logic [1:0] last, input int k);
    logic [2:0] s;
    s = {1'b0, last} + 3'(k);
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign busy       = (state_reg != IDLE);
  assign start      = (state_reg == IDLE) && (|bus.req_wreq);
  assign finish     = busy && bus.ddr_wdone;
  assign beat_total = beat_cnt_reg + LEN_WIDTH'(bus.ddr_wdata_req);

  // Scan the rotation backwards so the requester nearest last_grant+1 wins.
  always_comb begin
    pick = 2'd3;
    for (int k = 3; k >= 1; k--) begin
      if (bus.req_wreq[rr_index(last_grant_reg, k)]) pick = rr_index(last_grant_reg, k);
    end
  end

  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (|bus.req_wreq) state_next = REQ;
      REQ: begin
        if (bus.ddr_wdone)          state_next = IDLE;
        else if (bus.ddr_wdata_req) state_next = DATA;
      end
      DATA: if (bus.ddr_wdone) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ddr_wreq = 1'b0;
    case (state_reg)
      REQ:     bus.ddr_wreq = 1'b1;
      default: bus.ddr_wreq = 1'b0;
    endcase
  end

  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      grant_reg      <= 2'd3;
      last_grant_reg <= 2'd2;
      waddr_reg      <= '0;
      wr_len_reg     <= '0;
      beat_cnt_reg   <= '0;
      len_err_reg    <= 1'b0;
    end else if (start) begin
      grant_reg    <= pick;
      waddr_reg    <= bus.req_waddr[pick*ADDR_WIDTH +: ADDR_WIDTH];
      wr_len_reg   <= bus.req_wr_len[pick*LEN_WIDTH +: LEN_WIDTH];
      beat_cnt_reg <= '0;
    end else if (busy) begin
      if (bus.ddr_wdata_req) beat_cnt_reg <= beat_total;
      if (finish) begin
        last_grant_reg <= grant_reg;
        grant_reg      <= 2'd3;
        if (beat_total != wr_len_reg) len_err_reg <= 1'b1;
      end
    end
  end

  // grant_reg is 3 whenever the FSM is idle, so stray engine strobes route nowhere.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_route
      assign bus.req_wdata_req[gi] = bus.ddr_wdata_req && (grant_reg == 2'(gi));
      assign bus.req_wdone[gi]     = bus.ddr_wdone     && (grant_reg == 2'(gi));
      assign req_data[gi]          = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    bus.ddr_wdata = '0;
    case (grant_reg)
      2'd0:    bus.ddr_wdata = req_data[0];
      2'd1:    bus.ddr_wdata = req_data[1];
      2'd2:    bus.ddr_wdata = req_data[2];
      default: bus.ddr_wdata = '0;
    endcase
  end

  assign bus.ddr_waddr  = waddr_reg;
  assign bus.ddr_wr_len = wr_len_reg;
  assign grant          = grant_reg;
  assign len_err        = len_err_reg;
endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Randomized + directed bench for ddr_wr_arbiter; a round-robin/beat-count model
// written from the arbitration rules predicts grant, routing and len_err.
module tb_ddr_wr_arbiter;
  localparam int AW = 27;
  localparam int LW = 16;
  localparam int DW = 32;
  localparam int BW = 8 * DW;

  logic       ddr_clk = 1'b0;
  logic       ddr_rst;
  logic [1:0] grant;
  logic       len_err;

  ddr_wr_arbiter_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DQ_WIDTH(DW)) bus ();

  ddr_wr_arbiter #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DQ_WIDTH(DW)) dut (
    .ddr_clk (ddr_clk),
    .ddr_rst (ddr_rst),
    .bus     (bus.master),
    .grant   (grant),
    .len_err (len_err)
  );

  always #5 ddr_clk = ~ddr_clk;

  int          checks = 0;
  int          errors = 0;
  int          model_last;
  bit          model_len_err;
  logic [AW-1:0] addr_t [3];
  logic [LW-1:0] len_t  [3];

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] m);
    bus.req_wreq = m;
    for (int i = 0; i < 3; i++) begin
      bus.req_waddr[i*AW +: AW]  = addr_t[i];
      bus.req_wr_len[i*LW +: LW] = len_t[i];
    end
  endtask

  task automatic rand_req(input logic [2:0] m);
    for (int i = 0; i < 3; i++) begin
      addr_t[i] = AW'($urandom);
      len_t[i]  = LW'($urandom_range(0, 12));
    end
    drive_req(m);
  endtask

  task automatic rand_data();
    for (int i = 0; i < (3 * BW) / 32; i++) bus.req_wdata[i*32 +: 32] = $urandom;
  endtask

  function automatic int rr_pick(input int last, input logic [2:0] m);
    for (int k = 1; k <= 3; k++) if (m[(last + k) % 3]) return (last + k) % 3;
    return 3;
  endfunction

  // One full burst from IDLE: grant, optional REQ wait, beats (with gaps), wdone.
  task automatic burst(input logic [2:0] m, input bit keep, input int delta,
                       input bit coincide, input logic [2:0] next_m, input string tag);
    int  w;
    int  beats;
    bit  done_sent;
    logic [2:0] onehot;
    drive_req(m);
    w = rr_pick(model_last, m);
    onehot = 3'(1 << w);
    #1;
    chk($sformatf("%s:wreq_idle", tag), BW'(bus.ddr_wreq), BW'(0));
    tick();
    $display("burst %s requester=%0d addr=%0h len=%0d", tag, w, addr_t[w], len_t[w]);
    chk($sformatf("%s:grant", tag), BW'(grant), BW'(w));
    chk($sformatf("%s:wreq_req", tag), BW'(bus.ddr_wreq), BW'(1));
    chk($sformatf("%s:waddr", tag), BW'(bus.ddr_waddr), BW'(addr_t[w]));
    chk($sformatf("%s:wr_len", tag), BW'(bus.ddr_wr_len), BW'(len_t[w]));
    if (!keep) bus.req_wreq[w] = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk($sformatf("%s:wreq_hold", tag), BW'(bus.ddr_wreq), BW'(1));
      chk($sformatf("%s:grant_hold", tag), BW'(grant), BW'(w));
    end
    beats = int'(len_t[w]) + delta;
    if (beats < 0) beats = 0;
    done_sent = 1'b0;
    for (int b = 0; b < beats; b++) begin
      rand_data();
      bus.ddr_wdata_req = 1'b1;
      if (coincide && b == beats - 1) begin
        bus.ddr_wdone = 1'b1;
        drive_req(next_m);
        done_sent = 1'b1;
      end
      #1;
      chk($sformatf("%s:wdata_req", tag), BW'(bus.req_wdata_req), BW'(onehot));
      chk($sformatf("%s:wdata", tag), bus.ddr_wdata, bus.req_wdata[w*BW +: BW]);
      if (done_sent) chk($sformatf("%s:wdone_beat", tag), BW'(bus.req_wdone), BW'(onehot));
      tick();
      bus.ddr_wdata_req = 1'b0;
      bus.ddr_wdone = 1'b0;
      if (!done_sent) begin
        chk($sformatf("%s:wreq_data", tag), BW'(bus.ddr_wreq), BW'(0));
        if ($urandom_range(0, 3) == 0) begin
          #1;
          chk($sformatf("%s:gap_route", tag), BW'(bus.req_wdata_req), BW'(0));
          tick();
        end
      end
    end
    if (!done_sent) begin
      bus.ddr_wdone = 1'b1;
      drive_req(next_m);
      #1;
      chk($sformatf("%s:wdone", tag), BW'(bus.req_wdone), BW'(onehot));
      tick();
      bus.ddr_wdone = 1'b0;
    end
    model_last = w;
    if (beats != int'(len_t[w])) model_len_err = 1'b1;
    chk($sformatf("%s:grant_idle", tag), BW'(grant), BW'(3));
    chk($sformatf("%s:wreq_after", tag), BW'(bus.ddr_wreq), BW'(0));
    chk($sformatf("%s:len_err", tag), BW'(len_err), BW'(model_len_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] m;
    logic [2:0] nm;
    int w;
    ddr_rst = 1'b1;
    bus.req_wreq = '0;
    bus.req_waddr = '0;
    bus.req_wr_len = '0;
    bus.req_wdata = '0;
    bus.ddr_wdata_req = 1'b0;
    bus.ddr_wdone = 1'b0;
    model_last = 2;
    model_len_err = 1'b0;
    #2;
    chk("rst:grant", BW'(grant), BW'(3));
    chk("rst:wreq", BW'(bus.ddr_wreq), BW'(0));
    chk("rst:waddr", BW'(bus.ddr_waddr), BW'(0));
    chk("rst:wr_len", BW'(bus.ddr_wr_len), BW'(0));
    chk("rst:len_err", BW'(len_err), BW'(0));
    tick();
    tick();
    ddr_rst = 1'b0;
    tick();

    // Stray engine strobes while idle must not route anywhere.
    bus.ddr_wdata_req = 1'b1;
    bus.ddr_wdone = 1'b1;
    #1;
    chk("idle:wdata_req", BW'(bus.req_wdata_req), BW'(0));
    chk("idle:wdone", BW'(bus.req_wdone), BW'(0));
    tick();
    bus.ddr_wdata_req = 1'b0;
    bus.ddr_wdone = 1'b0;
    chk("idle:state", BW'(bus.ddr_wreq), BW'(0));

    // All three requesting continuously: expect 0,1,2,0.
    rand_req(3'b111);
    for (int i = 0; i < 4; i++) begin
      w = rr_pick(model_last, 3'b111);
      chk($sformatf("rr%0d:order", i), BW'(w), BW'((i == 3) ? 0 : i));
      burst(3'b111, 1'b1, 0, i[0], (i == 3) ? 3'b000 : 3'b111, $sformatf("rr%0d", i));
    end

    // Single requester 1, 0x100, 16 beats.
    addr_t[1] = AW'(27'h100);
    len_t[1] = LW'(16);
    burst(3'b010, 1'b0, 0, 1'b0, 3'b000, "single1");

    // Requester 2 short by one beat, then correct bursts keep the flag.
    len_t[2] = LW'(8);
    burst(3'b100, 1'b0, -1, 1'b0, 3'b000, "short2");
    rand_req(3'b011);
    burst(3'b011, 1'b0, 0, 1'b0, 3'b000, "after_err_a");
    rand_req(3'b001);
    len_t[0] = LW'(0);
    burst(3'b001, 1'b0, 0, 1'b0, 3'b000, "zero_len");

    // wdone coincident with a fresh request from requester 0.
    rand_req(3'b010);
    burst(3'b010, 1'b0, 0, 1'b0, 3'b001, "coinc_a");
    burst(3'b001, 1'b0, 0, 1'b0, 3'b000, "coinc_b");

    // Reset in the middle of a data phase.
    rand_req(3'b100);
    len_t[2] = LW'(6);
    drive_req(3'b100);
    tick();
    bus.req_wreq = 3'b000;
    rand_data();
    bus.ddr_wdata_req = 1'b1;
    tick();
    bus.ddr_wdata_req = 1'b0;
    tick();
    #2;
    ddr_rst = 1'b1;
    bus.ddr_wdone = 1'b1;
    #1;
    chk("midrst:grant", BW'(grant), BW'(3));
    chk("midrst:wreq", BW'(bus.ddr_wreq), BW'(0));
    chk("midrst:wdone_route", BW'(bus.req_wdone), BW'(0));
    chk("midrst:len_err", BW'(len_err), BW'(0));
    tick();
    bus.ddr_wdone = 1'b0;
    ddr_rst = 1'b0;
    model_last = 2;
    model_len_err = 1'b0;
    tick();
    rand_req(3'b111);
    burst(3'b111, 1'b0, 0, 1'b0, 3'b000, "post_rst");

    // Randomized bursts.
    m = 3'($urandom_range(1, 7));
    rand_req(m);
    for (int it = 0; it < 30; it++) begin
      int d;
      d = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? -1 : 1) : 0;
      nm = 3'($urandom_range(0, 7));
      burst(m, 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), nm,
            $sformatf("rnd%0d", it));
      if (nm == 3'b000) begin
        repeat ($urandom_range(0, 2)) tick();
        m = 3'($urandom_range(1, 7));
      end else begin
        m = nm;
      end
      rand_req(m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
